// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides,
// with divide-by-zero and quotient-overflow flags. Define RESTORING_DIV_SIGNED_EN for two's-complement operands.
module restoring_divider_seq #(
    parameter int QW = 4,
    parameter int VW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QW+VW-1:0]     x,
    input  logic [VW-1:0]        y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QW-1:0]        q,
    output logic [VW-1:0]        r,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int DW = QW + VW;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [VW:0]     rem;
    logic [VW-1:0]   dvs;
    logic [QW-1:0]   sr;

    logic [DW-1:0]   xm;
    logic [VW-1:0]   ym;
    logic            div_zero, quo_big, accept;

    logic [VW:0]     rem_sh, trial, rem_nxt;
    logic            qbit;
    logic [QW-1:0]   sr_nxt;

    logic [QW-1:0]   q_fin;
    logic [VW-1:0]   r_fin;
    logic            ovf_fin;

`ifdef RESTORING_DIV_SIGNED_EN
    localparam logic [QW-1:0] QMAXP = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMAXN = {1'b1, {(QW-1){1'b0}}};
    logic neg_q, neg_r;

    always_comb begin
        xm = x[DW-1] ? (~x + 1'b1) : x;
        ym = y[VW-1] ? (~y + 1'b1) : y;
    end
`else
    always_comb begin
        xm = x;
        ym = y;
    end
`endif

    // The quotient only fits in QW bits when the upper dividend bits are below the divisor.
    always_comb begin
        div_zero = (ym == '0);
        quo_big  = (DW'(xm[DW-1:VW]) >= DW'(ym));
        accept   = in_valid && (state == IDLE);
    end

    always_comb begin
        rem_sh  = {rem[VW-1:0], sr[QW-1]};
        trial   = rem_sh - {1'b0, dvs};
        qbit    = ~trial[VW];
        rem_nxt = qbit ? trial : rem_sh;
        sr_nxt  = (sr << 1) | QW'(qbit);
    end

    always_comb begin
        q_fin   = sr_nxt;
        r_fin   = rem_nxt[VW-1:0];
        ovf_fin = 1'b0;
`ifdef RESTORING_DIV_SIGNED_EN
        ovf_fin = neg_q ? (sr_nxt > QMAXN) : (sr_nxt > QMAXP);
        if (ovf_fin) begin
            q_fin = '1;
            r_fin = '0;
        end else begin
            q_fin = neg_q ? (~sr_nxt + 1'b1) : sr_nxt;
            r_fin = neg_r ? (~rem_nxt[VW-1:0] + 1'b1) : rem_nxt[VW-1:0];
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE: if (in_valid) state_nxt = (div_zero || quo_big) ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CW'(QW);
                if (div_zero) begin
                    dbz <= 1'b1;
                    ovf <= 1'b0;
                    q   <= '1;
                    r   <= '0;
                end else if (quo_big) begin
                    dbz <= 1'b0;
                    ovf <= 1'b1;
                    q   <= '1;
                    r   <= '0;
                end
            end else if (state == CALC) begin
                cnt <= cnt - CW'(1);
                // Results are published only on the final step so nothing partial is ever visible.
                if (cnt == CW'(1)) begin
                    q   <= q_fin;
                    r   <= r_fin;
                    dbz <= 1'b0;
                    ovf <= ovf_fin;
                end
            end
        end
    end

    // Working datapath registers need no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem <= {1'b0, xm[DW-1:QW]};
            sr  <= xm[QW-1:0];
            dvs <= ym;
`ifdef RESTORING_DIV_SIGNED_EN
            neg_q <= x[DW-1] ^ y[VW-1];
            neg_r <= x[DW-1];
`endif
        end else if (state == CALC) begin
            rem <= rem_nxt;
            sr  <= sr_nxt;
        end
    end

endmodule

// File: doc/restoring_divider_seq.md
Name: restoring_divider_seq

Overview:
- Sequential, parametrised successor to the combinational restoring array divider.
- Divides a DW = QW+VW bit dividend by a VW-bit divisor with one restoring step per clock; produces a QW-bit quotient and a VW-bit remainder.
- Valid/ready handshakes on both sides so it drops into the datapath between producer and consumer stages.
- Flags divide-by-zero and quotient overflow instead of returning garbage.

Parameters:
- QW, 4, quotient width and number of iteration cycles
- VW, 4, divisor and remainder width
- DW (localparam), QW+VW, dividend width; not overridable

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- x  in  DW  dividend
- y  in  VW  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  QW  quotient
- r  out  VW  remainder
- dbz  out  1  divide-by-zero flag, qualified by out_valid
- ovf  out  1  quotient-overflow flag, qualified by out_valid

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1; out_valid=0; q, r, dbz and ovf all 0; iteration counter 0.
- States: IDLE, CALC, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept: on the edge where in_valid && in_ready:
  - y==0: go to DONE with dbz=1, ovf=0, q=all-ones, r=0.
  - else if x[DW-1:VW] >= y: go to DONE with ovf=1, dbz=0, q=all-ones, r=0. The quotient does not fit in QW bits.
  - else: latch divisor; partial remainder = x[DW-1:QW] as VW+1 bits; shift register = x[QW-1:0]; counter=QW; go to CALC.
- CALC step, each edge:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - Trial = rem - divisor over VW+1 bits.
  - If trial is non-negative: rem=trial and shift a 1 into q. Otherwise restore rem and shift a 0 into q.
  - Decrement counter; when it goes 1 -> 0, move to DONE with r = rem[VW-1:0].
- Latency: out_valid high QW+1 edges after the accept edge for normal divides, and 1 edge after for dbz or ovf.
- DONE: q, r, dbz and ovf hold stable while out_valid && !out_ready (backpressure). On the edge with out_ready=1, return to IDLE. Outputs hold their last values; only out_valid drops.
- in_valid while busy is ignored. Operands are consumed only on the accept edge, so x and y may change during CALC.
- rst_n asserted mid-CALC or in DONE aborts immediately to reset values. No partial result is ever presented.
- Invariant for a normal result: x == q*y + r and r < y.

Optional Feature:
- Macro: RESTORING_DIV_SIGNED_EN
- Defined:
  - x, y, q and r are two's complement.
  - The core divides magnitudes. q is negated when sign(x) xor sign(y). r takes the sign of x (truncating division).
  - ovf is set when the magnitude quotient exceeds the signed QW range: above 2^(QW-1)-1, or above 2^(QW-1) when the result is negative.
  - Sign fix-up is applied on entry to DONE. Latency is unchanged.
- Undefined: all operands are unsigned, and no sign logic is synthesised.

Test Plan:
- Reset, then x=8, y=4 with out_ready=1 -> out_valid exactly 5 edges after accept; q=2, r=0, dbz=0, ovf=0.
- Back-to-back x=40,y=13; x=17,y=5; x=5,y=5 -> q=3,r=1; q=3,r=2; q=1,r=0. in_ready low during CALC and DONE.
- x=80, y=5 -> ovf=1, q=4'hF, out_valid after 1 edge. x=12, y=0 -> dbz=1, ovf=0, q=4'hF, r=0.
- Backpressure: hold out_ready=0 for 10 cycles after x=20,y=5 -> q=4, r=0 stable throughout; a new in_valid is not accepted until out_ready is pulsed.
- Assert rst_n=0 at the second CALC cycle of x=15,y=3 -> all outputs zero immediately; after release, x=15,y=3 -> q=5, r=0.
- With RESTORING_DIV_SIGNED_EN: x=-7 (8'hF9), y=2 -> q=4'hD (-3), r=4'hF (-1). x=64, y=-1 -> ovf=1.
